// File: rtl/atm_controller.sv
// Four-state ATM request controller: IDLE -> CHECK -> UPDATE -> RESP over a bank of account balances.
// Optional feature macro: ATM_TXN_COUNT_EN adds a 16-bit txn_count output of successful responses.
module atm_controller #(
  parameter int N_ACC    = 15,
  parameter int ACC_W    = 4,
  parameter int BAL_W    = 10,
  parameter int INIT_BAL = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       select,
  input  logic [ACC_W-1:0] accnumber_origin,
  input  logic [ACC_W-1:0] accnumber_purpose,
  input  logic [BAL_W-1:0] amount,
  output logic             resp_valid,
  output logic [1:0]       result,
  output logic [BAL_W-1:0] inventory
`ifdef ATM_TXN_COUNT_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_RESP} state_t;

  localparam logic [1:0] OP_QUERY    = 2'd1;
  localparam logic [1:0] OP_WITHDRAW = 2'd2;
  localparam logic [1:0] OP_TRANSFER = 2'd3;
  localparam logic [1:0] RES_REJECT  = 2'd0;
  localparam logic [1:0] RES_INSUF   = 2'd1;
  localparam logic [1:0] RES_REFUSED = 2'd2;
  localparam logic [1:0] RES_OK      = 2'd3;
  localparam logic [ACC_W:0]   LP_N_ACC = (ACC_W+1)'(N_ACC);
  localparam logic [BAL_W-1:0] LP_INIT  = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] LP_MAX   = {BAL_W{1'b1}};

  state_t r_state, w_next;
  logic [1:0]       r_sel;
  logic [ACC_W-1:0] r_orig, r_dest;
  logic [BAL_W-1:0] r_amt;
  logic [BAL_W-1:0] r_bal [N_ACC];
  logic [1:0]       r_res;
  logic [BAL_W-1:0] r_inv, r_new_o, r_new_d;
  logic             r_wr_o, r_wr_d;
  logic             r_resp_valid;
  logic [1:0]       r_result;
  logic [BAL_W-1:0] r_inventory;

  logic             w_orig_ok, w_dest_ok;
  logic [BAL_W-1:0] w_bal_o, w_bal_d, w_room;
  logic [1:0]       w_res;
  logic [BAL_W-1:0] w_inv, w_new_o, w_new_d;
  logic             w_wr_o, w_wr_d;

  assign w_orig_ok = ({1'b0, r_orig} < LP_N_ACC);
  assign w_dest_ok = ({1'b0, r_dest} < LP_N_ACC);
  assign w_bal_o   = w_orig_ok ? r_bal[r_orig] : '0;
  assign w_bal_d   = w_dest_ok ? r_bal[r_dest] : '0;
  // Destination can absorb the credit only if it does not exceed the remaining headroom.
  assign w_room    = LP_MAX - r_amt;

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign result     = r_result;
  assign inventory  = r_inventory;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = req_valid ? S_CHECK : S_IDLE;
      S_CHECK:  w_next = S_UPDATE;
      S_UPDATE: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_res   = RES_REJECT;
    w_inv   = '0;
    w_wr_o  = 1'b0;
    w_wr_d  = 1'b0;
    w_new_o = w_bal_o;
    w_new_d = w_bal_d;
    case (r_sel)
      OP_QUERY: begin
        if (w_orig_ok) begin
          w_res = RES_OK;
          w_inv = w_bal_o;
        end else begin
          w_res = RES_REJECT;
        end
      end
      OP_WITHDRAW: begin
        if (!w_orig_ok) begin
          w_res = RES_REJECT;
        end else if (w_bal_o >= r_amt) begin
          w_res   = RES_OK;
          w_wr_o  = 1'b1;
          w_new_o = w_bal_o - r_amt;
          w_inv   = w_bal_o - r_amt;
        end else begin
          w_res = RES_INSUF;
          w_inv = w_bal_o;
        end
      end
      OP_TRANSFER: begin
        if (!(w_orig_ok && w_dest_ok)) begin
          w_res = RES_REJECT;
        end else if (w_bal_o < r_amt) begin
          w_res = RES_REFUSED;
          w_inv = w_bal_o;
        end else if (r_orig == r_dest) begin
          // Self-transfer nets to zero, so the headroom test does not apply.
          w_res = RES_OK;
          w_inv = w_bal_o;
        end else if (w_bal_d > w_room) begin
          w_res = RES_REFUSED;
          w_inv = w_bal_o;
        end else begin
          w_res   = RES_OK;
          w_wr_o  = 1'b1;
          w_wr_d  = 1'b1;
          w_new_o = w_bal_o - r_amt;
          w_new_d = w_bal_d + r_amt;
          w_inv   = w_bal_o - r_amt;
        end
      end
      default: w_res = RES_REJECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= 2'd0;
      r_orig       <= '0;
      r_dest       <= '0;
      r_amt        <= '0;
      r_res        <= RES_REJECT;
      r_inv        <= '0;
      r_new_o      <= '0;
      r_new_d      <= '0;
      r_wr_o       <= 1'b0;
      r_wr_d       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_result     <= RES_REJECT;
      r_inventory  <= '0;
      for (int i = 0; i < N_ACC; i++) r_bal[i] <= LP_INIT;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sel  <= select;
            r_orig <= accnumber_origin;
            r_dest <= accnumber_purpose;
            r_amt  <= amount;
          end
        end
        S_CHECK: begin
          r_res   <= w_res;
          r_inv   <= w_inv;
          r_wr_o  <= w_wr_o;
          r_wr_d  <= w_wr_d;
          r_new_o <= w_new_o;
          r_new_d <= w_new_d;
        end
        S_UPDATE: begin
          // All balance writes of the transaction land on this one edge.
          for (int i = 0; i < N_ACC; i++) begin
            if (r_wr_o && (r_orig == ACC_W'(i)))      r_bal[i] <= r_new_o;
            else if (r_wr_d && (r_dest == ACC_W'(i))) r_bal[i] <= r_new_d;
          end
          r_resp_valid <= 1'b1;
          r_result     <= r_res;
          r_inventory  <= r_inv;
        end
        default: r_resp_valid <= 1'b0;
      endcase
    end
  end

`ifdef ATM_TXN_COUNT_EN
  logic [15:0] r_txn_count;
  assign txn_count = r_txn_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_txn_count <= 16'd0;
    else if ((r_state == S_RESP) && (r_result == RES_OK)) r_txn_count <= r_txn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller with default parameters (15 accounts, 10-bit balances, 100 each).
module tb_atm_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] select;
  logic [3:0] accnumber_origin;
  logic [3:0] accnumber_purpose;
  logic [9:0] amount;
  logic       resp_valid;
  logic [1:0] result;
  logic [9:0] inventory;
`ifdef ATM_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;

  atm_controller dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .select            (select),
    .accnumber_origin  (accnumber_origin),
    .accnumber_purpose (accnumber_purpose),
    .amount            (amount),
    .resp_valid        (resp_valid),
    .result            (result),
    .inventory         (inventory)
`ifdef ATM_TXN_COUNT_EN
    ,
    .txn_count         (txn_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE and check the full 4-cycle response timeline.
  task automatic do_req(input string tag, input logic [1:0] sel, input logic [3:0] o,
                        input logic [3:0] d, input logic [9:0] amt,
                        input logic [1:0] er, input logic [9:0] ei);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; select = sel; accnumber_origin = o; accnumber_purpose = d; amount = amt;
    @(negedge clk);
    req_valid = 1'b0;
    select = 2'($urandom); accnumber_origin = 4'($urandom);
    accnumber_purpose = 4'($urandom); amount = 10'($urandom);
    check({tag, "_busy"}, req_ready, 0);
    check({tag, "_rv_c1"}, resp_valid, 0);
    @(negedge clk);
    check({tag, "_rv_c2"}, resp_valid, 0);
    @(negedge clk);
    check({tag, "_rv_c3"}, resp_valid, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_inv"}, inventory, ei);
    if (er == 2'd3) exp_txn++;
    @(negedge clk);
    check({tag, "_rv_off"}, resp_valid, 0);
    check({tag, "_result_hold"}, result, er);
    check({tag, "_inv_hold"}, inventory, ei);
`ifdef ATM_TXN_COUNT_EN
    check({tag, "_txn"}, txn_count, exp_txn);
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; select = 2'd0;
    accnumber_origin = 4'd0; accnumber_purpose = 4'd0; amount = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", result, 0);
    check("rst_inventory", inventory, 0);
`ifdef ATM_TXN_COUNT_EN
    check("rst_txn", txn_count, 0);
`endif
    rst = 1'b0;
    #1;
    check("rst_ready", req_ready, 1);

    do_req("q5", 2'd1, 4'd5, 4'd0, 10'd0, 2'd3, 10'd100);
    do_req("wd40", 2'd2, 4'd2, 4'd0, 10'd40, 2'd3, 10'd60);
    do_req("wd70", 2'd2, 4'd2, 4'd0, 10'd70, 2'd1, 10'd60);
    do_req("xf0to1", 2'd3, 4'd0, 4'd1, 10'd100, 2'd3, 10'd0);
    do_req("q1", 2'd1, 4'd1, 4'd0, 10'd0, 2'd3, 10'd200);

    // Nine donors of 100 lift account 3 to 1000.
    do_req("fill5", 2'd3, 4'd5, 4'd3, 10'd100, 2'd3, 10'd0);
    for (int a = 6; a <= 14; a++) begin
      if (a != 7) do_req("fill", 2'd3, 4'(a), 4'd3, 10'd100, 2'd3, 10'd0);
    end
    do_req("q3_1000", 2'd1, 4'd3, 4'd0, 10'd0, 2'd3, 10'd1000);
    do_req("xf_ovf", 2'd3, 4'd4, 4'd3, 10'd100, 2'd2, 10'd100);
    do_req("q4_same", 2'd1, 4'd4, 4'd0, 10'd0, 2'd3, 10'd100);
    do_req("q3_same", 2'd1, 4'd3, 4'd0, 10'd0, 2'd3, 10'd1000);
    do_req("xf_to_max", 2'd3, 4'd4, 4'd3, 10'd23, 2'd3, 10'd77);
    do_req("q3_max", 2'd1, 4'd3, 4'd0, 10'd0, 2'd3, 10'd1023);

    do_req("xf_insuf", 2'd3, 4'd0, 4'd2, 10'd1, 2'd2, 10'd0);
    do_req("xf_self", 2'd3, 4'd2, 4'd2, 10'd60, 2'd3, 10'd60);
    do_req("q2_self", 2'd1, 4'd2, 4'd0, 10'd0, 2'd3, 10'd60);
    do_req("wd0_empty", 2'd2, 4'd0, 4'd0, 10'd0, 2'd3, 10'd0);
    do_req("xf0_full", 2'd3, 4'd0, 4'd3, 10'd0, 2'd3, 10'd0);

    do_req("q15", 2'd1, 4'd15, 4'd0, 10'd0, 2'd0, 10'd0);
    do_req("sel0", 2'd0, 4'd1, 4'd2, 10'd5, 2'd0, 10'd0);
    do_req("xf_bad_dst", 2'd3, 4'd1, 4'd15, 10'd10, 2'd0, 10'd0);
    do_req("q1_after", 2'd1, 4'd1, 4'd0, 10'd0, 2'd3, 10'd200);
    do_req("wd_exact", 2'd2, 4'd1, 4'd0, 10'd200, 2'd3, 10'd0);

    // Abort a withdraw of 50 from account 7 while it sits in UPDATE.
    req_valid = 1'b1; select = 2'd2; accnumber_origin = 4'd7; amount = 10'd50;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rv", resp_valid, 0);
    check("abort_result", result, 0);
    check("abort_inv", inventory, 0);
    exp_txn = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
`ifdef ATM_TXN_COUNT_EN
    check("abort_txn", txn_count, 0);
`endif
    do_req("q7_restored", 2'd1, 4'd7, 4'd0, 10'd0, 2'd3, 10'd100);
    do_req("q2_restored", 2'd1, 4'd2, 4'd0, 10'd0, 2'd3, 10'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
